// File: rtl/lpc_capture_ctrl_pkg.sv
// Shared types for the LPC capture path: queued entry layout, serializer states, record helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package lpc_capture_ctrl_pkg;

   // Decoded transaction as captured from the decoder: {cyctype_dir, size, addr, data}
   localparam int ENTRY_W = 71;

   // Cycle-type/direction codes as produced by the decoder
   localparam logic [3:0] CT_IO_RD  = 4'b0000;
   localparam logic [3:0] CT_IO_WR  = 4'b0010;
   localparam logic [3:0] CT_MEM_RD = 4'b0100;
   localparam logic [3:0] CT_MEM_WR = 4'b0110;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HDR  = 2'd1,
      ST_ADDR = 2'd2,
      ST_DATA = 2'd3
   } state_e;

   typedef struct packed {
      logic [3:0]  cyctype_dir;
      logic [2:0]  size;
      logic [31:0] addr;
      logic [31:0] data;
   } entry_t;

   // FIFO word: the entry plus the overflow flag latched when it was accepted
   typedef struct packed {
      logic   ovf;
      entry_t ent;
   } qword_t;

   localparam int QW_W = ENTRY_W + 1;

   // Number of data bytes emitted for a given decoder size (sizes above 4 clamp to 4)
   function automatic logic [2:0] data_bytes(input logic [2:0] size);
      return (size > 3'd4) ? 3'd4 : size;
   endfunction

   // Header byte: {cyctype_dir[3:0], ovf, size[2:0]}
   function automatic logic [7:0] make_hdr(input qword_t q);
      return {q.ent.cyctype_dir, q.ovf, q.ent.size};
   endfunction

endpackage

// File: rtl/lpc_fifo.sv
// Synchronous FIFO with first-word-fall-through head and occupancy output.
// Latency: write visible at dout/empty the cycle after push.
// Backpressure: push ignored when full unless a pop frees a slot in the same cycle.
module lpc_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                    lpc_clock,
   input  logic                    lpc_reset,
   input  logic                    push,
   input  logic                    pop,
   input  logic [WIDTH-1:0]        din,
   output logic [WIDTH-1:0]        dout,
   output logic                    full,
   output logic                    empty,
   output logic [$clog2(DEPTH):0]  level
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic             w_do_push;
   logic             w_do_pop;

   // Extra pointer MSB separates full (MSBs differ) from empty (pointers equal)
   assign empty     = (r_wr_ptr == r_rd_ptr);
   assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_do_pop  = pop & ~empty;
   assign w_do_push = push & (~full | w_do_pop);
   assign level     = r_wr_ptr - r_rd_ptr;
   assign dout      = r_mem[r_rd_ptr[AW-1:0]];

   // Storage write; when full with a pop, the slot being read out is overwritten at the same edge
   always_ff @(posedge lpc_clock) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr[AW-1:0]] <= din;
      end
   end

   // Read/write pointers, wrapping modulo 2*DEPTH
   always_ff @(posedge lpc_clock or negedge lpc_reset) begin
      if (!lpc_reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

endmodule

// File: rtl/lpc_capture_ctrl.sv
// Filters decoded LPC transactions, queues them and serializes each as a byte record.
// Latency: strobe at edge N -> FIFO write at N -> load at N+1 -> header valid after N+1.
// Backpressure: tx bytes held until tx_ready; full FIFO drops entries and flags the next record.
module lpc_capture_ctrl
   import lpc_capture_ctrl_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                    lpc_clock,
   input  logic                    lpc_reset,
   input  logic [3:0]              in_cyctype_dir,
   input  logic [31:0]             in_addr,
   input  logic [31:0]             in_data,
   input  logic [2:0]              in_data_size,
   input  logic                    in_valid,
   input  logic                    cfg_enable,
   input  logic [15:0]             cfg_type_mask,
   output logic [7:0]              tx_data,
   output logic                    tx_valid,
   input  logic                    tx_ready,
   output logic [7:0]              ovf_count,
   output logic [$clog2(DEPTH):0]  fifo_level
);

   qword_t     w_din;
   qword_t     w_head;
   logic       w_full;
   logic       w_empty;
   logic       w_accept;
   logic       w_push;
   logic       w_pop;
   logic       w_drop;
   logic       w_hs;
   logic [2:0] w_nbytes;

   state_e     r_state;
   state_e     w_state_nxt;
   logic [1:0] r_idx;
   logic [1:0] w_idx_nxt;
   qword_t     r_cur;
   logic [7:0] r_ovf_count;
   logic       r_ovf_pending;

   // Filter: mask is sampled together with the strobe, so queued entries are unaffected by later changes
   assign w_accept = in_valid & cfg_enable & cfg_type_mask[in_cyctype_dir];
   // A pop in the same cycle frees a slot, so a full FIFO only drops when nothing is leaving
   assign w_push   = w_accept & (~w_full | w_pop);
   assign w_drop   = w_accept & w_full & ~w_pop;
   assign w_hs     = tx_valid & tx_ready;
   assign w_nbytes = data_bytes(r_cur.ent.size);

   assign w_din = '{ovf: r_ovf_pending,
                    ent: '{cyctype_dir: in_cyctype_dir, size: in_data_size,
                           addr: in_addr, data: in_data}};

   lpc_fifo #(
      .WIDTH (QW_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .lpc_clock (lpc_clock),
      .lpc_reset (lpc_reset),
      .push      (w_push),
      .pop       (w_pop),
      .din       (w_din),
      .dout      (w_head),
      .full      (w_full),
      .empty     (w_empty),
      .level     (fifo_level)
   );

   // Drop counter (saturating) and pending flag carried into the next queued entry
   always_ff @(posedge lpc_clock or negedge lpc_reset) begin
      if (!lpc_reset) begin
         r_ovf_count   <= '0;
         r_ovf_pending <= 1'b0;
      end else begin
         if (w_push) r_ovf_pending <= 1'b0;
         if (w_drop) begin
            r_ovf_pending <= 1'b1;
            if (r_ovf_count != 8'hFF) r_ovf_count <= r_ovf_count + 8'd1;
         end
      end
   end

   assign ovf_count = r_ovf_count;

   // Serializer state, byte index and the record currently being sent
   always_ff @(posedge lpc_clock or negedge lpc_reset) begin
      if (!lpc_reset) begin
         r_state <= ST_IDLE;
         r_idx   <= '0;
         r_cur   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
         if (w_pop) r_cur <= w_head;
      end
   end

   // Next-state: IDLE loads the head, then header, 4 address bytes, n data bytes
   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_pop       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (!w_empty) begin
               w_pop       = 1'b1;
               w_state_nxt = ST_HDR;
            end
         end
         ST_HDR: begin
            if (w_hs) begin
               w_state_nxt = ST_ADDR;
               w_idx_nxt   = 2'd0;
            end
         end
         ST_ADDR: begin
            if (w_hs) begin
               if (r_idx == 2'd3) begin
                  w_idx_nxt   = 2'd0;
                  w_state_nxt = (w_nbytes != 3'd0) ? ST_DATA : ST_IDLE;
               end else begin
                  w_idx_nxt = r_idx + 2'd1;
               end
            end
         end
         ST_DATA: begin
            if (w_hs) begin
               if ({1'b0, r_idx} == (w_nbytes - 3'd1)) begin
                  w_idx_nxt   = 2'd0;
                  w_state_nxt = ST_IDLE;
               end else begin
                  w_idx_nxt = r_idx + 2'd1;
               end
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_idx_nxt   = 2'd0;
         end
      endcase
   end

   // Byte mux: outputs derive only from registers, so they hold until the handshake edge
   always_comb begin
      tx_valid = (r_state != ST_IDLE);
      tx_data  = 8'h00;
      case (r_state)
         ST_HDR:  tx_data = make_hdr(r_cur);
         ST_ADDR: begin
            case (r_idx)
               2'd0:    tx_data = r_cur.ent.addr[31:24];
               2'd1:    tx_data = r_cur.ent.addr[23:16];
               2'd2:    tx_data = r_cur.ent.addr[15:8];
               default: tx_data = r_cur.ent.addr[7:0];
            endcase
         end
         ST_DATA: tx_data = r_cur.ent.data[{r_idx, 3'b000} +: 8];
         default: tx_data = 8'h00;
      endcase
   end

endmodule
